// File: rtl/golden_nonce_collector_if.sv
// Golden-nonce output handshake: the collector drives valid/nonce, the host side drives ready.
interface golden_nonce_collector_if;
  logic        gn_valid;
  logic [31:0] gn_nonce;
  logic        gn_ready;

  modport master (output gn_valid, output gn_nonce, input gn_ready);
  modport slave  (input gn_valid, input gn_nonce, output gn_ready);
endinterface

// File: rtl/golden_nonce_collector.sv
// Issues nonces into the hash pipelines, flags returned hash words equal to TARGET and buffers
// the recovered nonces in a small FIFO. Define GN_HIT_COUNT_EN to add the hit_count port.
//
// state | meaning
// IDLE  | no work loaded since reset, nonce_out holds
// RUN   | nonce_out advances by one every cycle
module golden_nonce_collector #(
  parameter int unsigned LATENCY = 268,
  parameter int unsigned DEPTH   = 4,
  parameter logic [31:0] TARGET  = 32'ha41f32e7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     new_work,
  input  logic [31:0]              start_nonce,
  output logic [31:0]              nonce_out,
  input  logic [31:0]              hash_in,
  golden_nonce_collector_if.master gn,
  output logic                     overflow
`ifdef GN_HIT_COUNT_EN
  ,
  output logic [15:0]              hit_count
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam int AW = $clog2(DEPTH);

  logic [0:0]         state;
  logic               running;
  logic [LATENCY-1:0] valid_sr;
  logic [LATENCY-1:0] sr_next;
  logic               out_valid;
  logic               hit_pend;
  logic [31:0]        hit_cand;
  logic [31:0]        mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               empty;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;

  assign running = (state == RUN);

  generate
    if (LATENCY > 1) begin : g_sr
      assign sr_next = {valid_sr[LATENCY-2:0], running};
    end else begin : g_sr1
      assign sr_next = running;
    end
  endgenerate

  assign out_valid = valid_sr[LATENCY-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      nonce_out <= '0;
      valid_sr  <= '0;
    end else if (new_work) begin
      // clearing the delay line discards results still in flight for the old work
      state     <= RUN;
      nonce_out <= start_nonce;
      valid_sr  <= '0;
    end else begin
      if (running) nonce_out <= nonce_out + 32'd1;
      valid_sr <= sr_next;
    end
  end

  // The hash on hash_in belongs to the nonce issued LATENCY cycles ago.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_pend <= 1'b0;
      hit_cand <= '0;
    end else begin
      hit_pend <= out_valid && (hash_in == TARGET);
      hit_cand <= nonce_out - 32'(LATENCY);
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop   = !empty && gn.gn_ready;
  assign push  = hit_pend && (!full || pop);
  assign drop  = hit_pend && full && !pop;

  assign gn.gn_valid = !empty;
  assign gn.gn_nonce = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= hit_cand;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || new_work) overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
  end

`ifdef GN_HIT_COUNT_EN
  logic [15:0] hit_cnt;

  always_ff @(posedge clk) begin
    if (reset || new_work)               hit_cnt <= '0;
    else if (hit_pend && hit_cnt != '1)  hit_cnt <= hit_cnt + 16'd1;
  end

  assign hit_count = hit_cnt;
`endif

endmodule

// File: tb/tb_golden_nonce_collector.sv
// Randomized scoreboard bench for golden_nonce_collector against a cycle-index reference model.
module tb_golden_nonce_collector;
  localparam int unsigned LAT = 8;
  localparam int unsigned DEP = 4;
  localparam logic [31:0] TGT = 32'ha41f32e7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_work = 1'b0;
  logic [31:0] start_nonce = '0;
  logic [31:0] hash_in = '0;
  logic [31:0] nonce_out;
  logic        overflow;
`ifdef GN_HIT_COUNT_EN
  logic [15:0] hit_count;
`endif

  golden_nonce_collector_if gnif();

  golden_nonce_collector #(.LATENCY(LAT), .DEPTH(DEP), .TARGET(TGT)) dut (
    .clk         (clk),
    .reset       (reset),
    .new_work    (new_work),
    .start_nonce (start_nonce),
    .nonce_out   (nonce_out),
    .hash_in     (hash_in),
    .gn          (gnif),
    .overflow    (overflow)
`ifdef GN_HIT_COUNT_EN
    ,
    .hit_count   (hit_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  // Reference model: nonce issued in cycle d is wstart + (d - t_start) for the current work.
  logic [31:0] exp_q[$];
  longint      cyc = 0;
  longint      t_start = -1;
  logic [31:0] wstart = '0;
  logic        m_pend = 1'b0;
  logic [31:0] m_pend_nonce = '0;
  logic        m_ovf = 1'b0;
  int          m_cnt = 0;
  logic        model_ok = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  function automatic logic [31:0] exp_nonce();
    if (t_start < 0) return 32'd0;
    return wstart + 32'(cyc - t_start);
  endfunction

  initial begin
    longint c;
    forever begin
      @(posedge clk);
      c = cyc;
      if (reset) begin
        t_start  = -1;
        wstart   = '0;
        m_pend   = 1'b0;
        m_ovf    = 1'b0;
        m_cnt    = 0;
        exp_q.delete();
        model_ok = 1'b1;
      end else begin
        // the monitor already removed the entry popped at this edge
        if (m_pend) begin
          if (m_cnt < 65535) m_cnt++;
          if (exp_q.size() < DEP) exp_q.push_back(m_pend_nonce);
          else m_ovf = 1'b1;
        end
        m_pend = 1'b0;
        if (hash_in == TGT && t_start >= 0 && c - LAT >= t_start) begin
          m_pend       = 1'b1;
          m_pend_nonce = wstart + 32'(c - LAT - t_start);
        end
        if (new_work) begin
          t_start = c + 1;
          wstart  = start_nonce;
          m_ovf   = 1'b0;
          m_cnt   = 0;
        end
      end
      cyc = c + 1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        chk("gn_valid", 32'(gnif.gn_valid), 32'(exp_q.size() > 0));
        chk("nonce_out", nonce_out, exp_nonce());
        chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef GN_HIT_COUNT_EN
        chk("hit_count", 32'(hit_count), 32'(m_cnt));
`endif
        if (exp_q.size() > 0) begin
          chk("gn_nonce", gnif.gn_nonce, exp_q[0]);
          if (gnif.gn_ready) begin
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end
    end
  end

  task automatic step(input logic r, input logic nw, input logic [31:0] s,
                      input logic [31:0] h, input logic rdy);
    reset         = r;
    new_work      = nw;
    start_nonce   = s;
    hash_in       = h;
    gnif.gn_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    gnif.gn_ready = 1'b0;
    repeat (3) step(1, 0, 0, 0, 0);
    // target on the bus while idle and during pipeline fill must not produce hits
    repeat (5) step(0, 0, 0, TGT, 1);
    step(0, 1, 32'h100, TGT, 1);
    for (int i = 0; i < 30; i++) step(0, 0, 0, (i % 3 == 0) ? TGT : $urandom, 1);

    // restart while old-work results are still in the pipeline
    step(0, 1, 32'h20, 0, 1);
    repeat (6) step(0, 0, 0, 0, 1);
    step(0, 1, 32'h9000, 0, 1);
    repeat (6) step(0, 0, 0, TGT, 1);
    repeat (6) step(0, 0, 0, $urandom, 1);

    // overflow: six hits into a four-entry FIFO, then pop on a full FIFO with a hit pending
    step(0, 1, 32'h5000, 0, 0);
    repeat (8) step(0, 0, 0, $urandom, 0);
    repeat (6) step(0, 0, 0, TGT, 0);
    step(0, 0, 0, $urandom, 1);
    repeat (3) step(0, 0, 0, $urandom, 0);
    repeat (6) step(0, 0, 0, $urandom, 1);

    // wrap through zero
    step(0, 1, 32'hfffffffe, 0, 1);
    repeat (8) step(0, 0, 0, 0, 1);
    repeat (12) step(0, 0, 0, TGT, 1);
    repeat (4) step(0, 0, 0, 0, 1);

    // reset with entries buffered and a hit pending
    step(0, 1, 32'h777, 0, 0);
    repeat (8) step(0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, TGT, 0);
    step(1, 0, 0, TGT, 0);
    repeat (4) step(0, 0, 0, TGT, 1);

    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 499) == 0,
           $urandom_range(0, 63) == 0,
           ($urandom_range(0, 7) == 0) ? (32'hffffffff - 32'($urandom_range(0, 3))) : $urandom,
           ($urandom_range(0, 2) == 0) ? TGT : $urandom,
           ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0));
    end

    repeat (20) step(0, 0, 0, 0, 1);
    chk("pops_seen", 32'(pops > 50), 32'd1);
    chk("drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/golden_nonce_collector.md
Name: golden_nonce_collector

Overview:
- Feeds the nonce stream into the SHA-256 hash pipelines and collects results at the pipeline output.
- Issues one nonce per clock and tracks which pipeline output cycles carry valid work.
- Compares each returned hash word against a target constant and recovers the matching nonce arithmetically.
- Buffers hits ("golden nonces") in a small FIFO that host-interface logic drains with a valid/ready handshake.

Parameters:
- LATENCY, 268: cycles from a nonce appearing on nonce_out to its hash word appearing on hash_in (sum of both pipeline depths plus glue). Must be >= 1.
- DEPTH, 4: golden-nonce FIFO entries. Must be a power of 2, >= 2.
- TARGET, 32'ha41f32e7: hash_in value that marks a hit.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- new_work  in  1  one-cycle pulse: load start_nonce, start or restart issuing.
- start_nonce  in  32  first nonce of the new work.
- nonce_out  out  32  nonce presented to the pipeline data word this cycle.
- hash_in  in  32  hash word from the pipeline output.
- gn_valid  out  1  FIFO not empty.
- gn_nonce  out  32  head-of-FIFO golden nonce.
- gn_ready  in  1  consumer accepts head when gn_valid=1.
- overflow  out  1  sticky: a hit was dropped because the FIFO was full.
- hit_count  out  16  present only with GN_HIT_COUNT_EN.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: nonce_out=0, running=0, delay line all 0, FIFO empty, gn_valid=0, gn_nonce=0, overflow=0, hit_count=0. Reset overrides new_work in the same cycle.
- States: IDLE (running=0) and RUN (running=1).
  - IDLE -> RUN on new_work.
  - new_work in RUN restarts RUN.
  - Only reset returns the block to IDLE.
- Nonce issue:
  - On new_work, nonce_out <= start_nonce.
  - Otherwise in RUN, nonce_out <= nonce_out+1 every cycle, mod 2^32; wraps 0xffffffff -> 0 silently.
  - In IDLE, nonce_out holds its value.
- Validity delay line: LATENCY-bit shift register, shifted every cycle.
  - Input bit = running after the update, i.e. 1 on the cycle nonce_out first shows a work's nonce.
  - new_work clears all bits, so in-flight results of old work are discarded.
  - out_valid = last bit.
- Nonce recovery: cand = nonce_out - LATENCY, mod 2^32. No per-nonce storage.
- Hit: out_valid && hash_in==TARGET, registered once. The FIFO push happens on the cycle after the hit is seen and stores the cand from the hit cycle.
- FIFO behaviour:
  - gn_valid = not empty; gn_nonce = head, held stable while gn_valid && !gn_ready.
  - Pop when gn_valid && gn_ready.
  - Push when a hit is pending and (not full, or pop this cycle). Simultaneous push and pop on a full FIFO is accepted.
  - Push with full and no pop: the hit is dropped and overflow <= 1.
- Hit-to-gn_valid latency from an empty FIFO: 2 cycles after hash_in is sampled.
- overflow clears only on reset or new_work. new_work does not flush the FIFO; hits already buffered remain valid results.
- A pending registered hit at new_work is still pushed.

Optional Feature:
- Macro: GN_HIT_COUNT_EN.
- Defined: port hit_count exists. It is a 16-bit counter incremented on every detected hit, pushed or dropped, and saturates at 0xffff. It clears on reset and new_work.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Basic hit (LATENCY=8, DEPTH=4): reset, new_work with start_nonce=0x100. Bench drives hash_in=TARGET exactly 8 cycles after nonce_out=0x105 -> gn_valid rises 2 cycles later, gn_nonce=0x105; one pop empties the FIFO.
- Pre-work garbage: hash_in=TARGET continuously while in IDLE and during the first 7 cycles of RUN -> no push. The first hit reports start_nonce.
- Restart: hash_in=TARGET for old-work nonce 0x20 arrives after new_work (start_nonce=0x9000) was pulsed 3 cycles earlier -> dropped, gn_valid stays 0, overflow=0.
- Overflow: 5 hits with gn_ready=0 and DEPTH=4 -> 4 entries held in order, overflow=1, hit_count=5 with the macro. On the 6th hit with gn_ready=1 on a full FIFO, the push is accepted and overflow stays 1.
- Wrap: start_nonce=0xfffffffe, hit at the third issued nonce -> gn_nonce=0x00000000. A hit with cand crossing the wrap boundary (nonce_out<LATENCY) also reports correctly.
- Reset mid-operation: reset with 2 entries buffered and a hit pending -> gn_valid=0, overflow=0, nonce_out=0, no push on the following cycle.
